// File: rtl/pipe_pkg.sv
// Shared types and default widths for the configurable pipeline stage register.
// A control bundle of all zeros is treated downstream as a bubble.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam int IF_ID_CTRL_W  = 16;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int ID_EX_DATA_W  = 133;
  localparam int EX_MEM_CTRL_W = 16;
  localparam int EX_MEM_DATA_W = 101;
  localparam int MEM_WB_CTRL_W = 16;
  localparam int MEM_WB_DATA_W = 69;

  localparam int MAX_CTRL_W = 64;
  localparam logic [MAX_CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_stage_entry.sv
// One held instruction: control and data registers with load enable.
// Clearing the control part takes priority over loading it.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= '0;
    end else if (clear) begin
      ctrl <= BUBBLE_CTRL[CTRL_W-1:0];
    end else if (load) begin
      ctrl <= in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (load) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage register with valid/ready handshake,
// optional skid entry, flush-to-bubble and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = ID_EX_CTRL_W,
  parameter int DATA_W      = ID_EX_DATA_W,
  parameter bit SKID_EN     = 1'b1,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  state_t state, state_nxt;

  logic in_fire, out_fire;
  logic main_load, main_clear, main_sel;
  logic skid_load, skid_clear;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_in_data;

  // With the skid entry, ready depends on state alone so that
  // out_ready never reaches in_ready combinationally.
  assign out_valid = (state != EMPTY);
  assign in_ready  = SKID_EN ? (state != SKID)
                             : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (in_fire) state_nxt = FULL;
        FULL: begin
          if (SKID_EN && in_fire && !out_ready)
            state_nxt = SKID;
          else if (!in_fire && out_fire)
            state_nxt = EMPTY;
        end
        SKID: if (out_fire) state_nxt = FULL;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    occupancy  = 2'd0;
    main_load  = 1'b0;
    main_clear = flush;
    main_sel   = 1'b0;
    skid_load  = 1'b0;
    skid_clear = flush;
    unique case (state)
      EMPTY: main_load = in_fire;
      FULL: begin
        occupancy = 2'd1;
        main_load = in_fire && out_fire;
        if (!in_fire && out_fire)
          main_clear = 1'b1;
        skid_load = SKID_EN && in_fire && !out_ready;
      end
      SKID: begin
        occupancy = 2'd2;
        main_load = out_fire;
        main_sel  = 1'b1;
      end
      default: occupancy = 2'd0;
    endcase
  end

  assign main_in_ctrl = main_sel ? skid_ctrl : in_ctrl;
  assign main_in_data = main_sel ? skid_data : in_data;

  pipe_stage_entry #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clear  (main_clear),
    .in_ctrl(main_in_ctrl),
    .in_data(main_in_data),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  if (SKID_EN) begin : g_skid
    pipe_stage_entry #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .clear  (skid_clear),
      .in_ctrl(in_ctrl),
      .in_data(in_data),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
    );
  end else begin : g_no_skid
    assign skid_ctrl = '0;
    assign skid_data = '0;
  end

  assign out_ctrl = main_ctrl;
  assign out_data = main_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: three stage-register variants on shared stimulus,
// checked against per-variant queue models of held instructions.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 16;

  typedef logic [CW+DW-1:0] pl_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic [2:0] rdy, ov;
  logic [CW-1:0] oc [3];
  logic [DW-1:0] od [3];
  logic [1:0] occ [3];
  logic [7:0] sc [3];
  logic [1:0] sc_small;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .STALL_CNT_W(8)
  ) u_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]),
    .occupancy(occ[0]), .stall_cnt(sc[0])
  );

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0), .STALL_CNT_W(8)
  ) u_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]),
    .occupancy(occ[1]), .stall_cnt(sc[1])
  );

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .STALL_CNT_W(2)
  ) u_c (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[2]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc[2]), .out_data(od[2]),
    .occupancy(occ[2]), .stall_cnt(sc_small)
  );

  assign sc[2] = {6'b0, sc_small};

  int errors = 0;
  int checks = 0;

  // Reference model: held count, capacity and stall count per variant.
  int held [3] = '{0, 0, 0};
  int cnt  [3] = '{0, 0, 0};
  int cmax [3] = '{255, 255, 3};
  int cap  [3] = '{2, 1, 2};
  bit acc  [3] = '{0, 0, 0};
  pl_t q0[$], q1[$], q2[$];

  function automatic void qpush(int i, pl_t v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic pl_t qpop(int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qclr(int i);
    case (i)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Depth-2 variants accept while not full; the single-entry
  // variant accepts when empty or when its entry leaves this cycle.
  function automatic bit mready(int i);
    if (cap[i] == 1) return (held[i] == 0) || out_ready;
    return held[i] < cap[i];
  endfunction

  task automatic chk(string nm, int i,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t",
               nm, i, act, exp, $time);
    end
  endtask

  task automatic rst_chk();
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", i, 32'(ov[i]), 32'd0);
      chk("rst_out_ctrl", i, 32'(oc[i]), 32'd0);
      chk("rst_out_data", i, 32'(od[i]), 32'd0);
      chk("rst_occupancy", i, 32'(occ[i]), 32'd0);
      chk("rst_stall_cnt", i, 32'(sc[i]), 32'd0);
      chk("rst_in_ready", i, 32'(rdy[i]), 32'd1);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      qclr(i);
      held[i] = 0;
      cnt[i]  = 0;
      acc[i]  = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge.
  task automatic cyc(bit v, pl_t pl, bit ordy, bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_ctrl   = pl[CW+DW-1:DW];
    in_data   = pl[DW-1:0];
    out_ready = ordy;
    flush     = fl;
    for (int i = 0; i < 3; i++) begin
      acc[i] = reset && v && mready(i);
      if (acc[i] && !fl) qpush(i, pl);
    end
  endtask

  task automatic async_rst();
    @(posedge clk);
    #3;
    reset = 1'b0;
    in_valid = 1'b0;
    model_clear();
    #1;
    rst_chk();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compares whatever the DUTs present against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit pop;
      pl_t exp;
      chk("out_valid", i, 32'(ov[i]), 32'(held[i] > 0));
      chk("occupancy", i, 32'(occ[i]), 32'(held[i]));
      chk("in_ready", i, 32'(rdy[i]), 32'(mready(i)));
      chk("stall_cnt", i, 32'(sc[i]), 32'(cnt[i]));
      if (!ov[i])
        chk("bubble_ctrl", i, 32'(oc[i]), 32'd0);
      pop = (held[i] > 0) && out_ready;
      if (pop) begin
        exp = qpop(i);
        if (ov[i])
          chk("payload", i, 32'({oc[i], od[i]}), 32'(exp));
      end
      if (held[i] > 0 && !out_ready && !flush && cnt[i] < cmax[i])
        cnt[i]++;
      if (flush) begin
        qclr(i);
        held[i] = 0;
      end else begin
        held[i] = held[i] - int'(pop) + int'(acc[i]);
      end
    end
  end

  function automatic pl_t mk(int k);
    return pl_t'({8'(k), 16'(k)});
  endfunction

  initial begin
    #2;
    rst_chk();
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int k = 1; k <= 8; k++) cyc(1'b1, mk(k), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    cyc(1'b1, mk(8'hA), 1'b0, 1'b0);
    cyc(1'b1, mk(8'hB), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b1, 1'b0);

    cyc(1'b1, mk(8'h1A), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h1B), 1'b0, 1'b0);
    cyc(1'b1, mk(8'hC), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b1, 1'b0);

    for (int k = 0; k < 16; k++)
      cyc(1'b1, mk(8'h20 + k), k[0], 1'b0);

    for (int k = 0; k < 5; k++)
      cyc(1'b1, mk(8'h40 + k), k[1], 1'b0);
    async_rst();
    for (int k = 0; k < 4; k++) cyc(1'b1, mk(8'h50 + k), 1'b1, 1'b0);

    for (int k = 0; k < 500; k++) begin
      if (k == 250) async_rst();
      cyc(($urandom % 4) != 0, pl_t'($urandom),
          ($urandom % 3) != 0, ($urandom % 25) == 0);
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register that replaces the fixed inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one configurable block. It carries a control bundle and a data bundle under a valid/ready handshake, with an optional skid entry that registers the upstream ready. It supports a synchronous flush that inserts an all-zero-control bubble. It also keeps a saturating back-pressure counter for the hazard unit and performance debug.

## Interface
Parameters:
- CTRL_W, 16, width of control bundle (RegWrite, MemtoReg, MemWrite, ALUControl, …); all-zero means bubble
- DATA_W, 133, width of data bundle (operands, immediate, PC+4, rw)
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, combinational in_ready
- STALL_CNT_W, 8, width of stall counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- flush  in  1  synchronous; drop all held entries and present a bubble
- in_valid  in  1  upstream stage has an instruction
- in_ready  out  1  this stage accepts the upstream instruction
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  downstream instruction present
- out_ready  in  1  downstream accepts the instruction
- out_ctrl  out  CTRL_W  registered control; zero whenever out_valid=0
- out_data  out  DATA_W  registered data; value is don't-care when out_valid=0
- occupancy  out  2  number of held entries (0..2)
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with out_valid & !out_ready

## Operation
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (0 entries), FULL (main entry only), SKID (main and skid entries; reachable only with SKID_EN=1).
- EMPTY: on in_fire, load main and go to FULL.
- FULL, in_fire & out_fire: reload main; stay in FULL.
- FULL, !in_fire & out_fire: go to EMPTY; clear main ctrl to 0.
- FULL, in_fire & !out_ready: load skid; go to SKID.
- SKID: no input is accepted. On out_fire, main takes skid; go to FULL.
- in_ready:
  - SKID_EN=1: in_ready = (state != SKID). This is a registered decode of the state; it has no combinational path from out_ready.
  - SKID_EN=0: in_ready = !out_valid | out_ready.
- out_valid = (state != EMPTY). out_ctrl and out_data come from main.
- Flush:
  - Highest priority: next state is EMPTY, and main ctrl and skid ctrl clear to 0.
  - Data registers are not required to clear.
  - An in_fire in the flush cycle completes its handshake, but the instruction is discarded.
- stall_cnt:
  - Increments each cycle that out_valid & !out_ready & !flush holds.
  - Saturates at all-ones.
  - Clears on reset only.
- occupancy: EMPTY=0, FULL=1, SKID=2.

## Timing
- Reset values (asynchronous, active-low): state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, skid registers=0.
- in_ready after reset:
  - SKID_EN=1: in_ready=1 immediately.
  - SKID_EN=0: in_ready=1, because out_valid=0.
- Latency: 1 cycle. An in_fire at edge N gives out_valid=1 with that payload after edge N.
- Throughput: 1 per cycle while out_ready=1.
- Ordering: strict FIFO order; the skid entry is never bypassed.
- Simultaneous flush + in_fire + out_fire: flush wins; the output is EMPTY after the edge.
- Reset asserted mid-transfer: all entries are lost immediately (asynchronous), with no glitch on out_ctrl beyond the clear to zero.
- Deassertion of reset must be synchronised externally to clk.

## Structure
- Shared package pipe_pkg:
  - state enum {EMPTY, FULL, SKID}
  - default CTRL_W/DATA_W constants per stage
  - BUBBLE_CTRL = '0
- One sub-module, pipe_stage_entry: a ctrl+data register with load enable and synchronous ctrl clear, on the async active-low reset. The block instantiates it twice (main and skid; skid only when SKID_EN=1).

## Test plan
- Reset, then stream 0x1..0x8 with out_ready=1: out_data appears 1 cycle later in order; in_ready stays 1; occupancy=1; stall_cnt=0.
- SKID_EN=1, hold out_ready=0 and push 0xA then 0xB: occupancy reaches 2 and in_ready drops. Release out_ready: 0xA, then 0xB emerge; stall_cnt equals the number of stalled cycles.
- flush while in SKID with in_valid=1 (payload 0xC): the next cycle has out_valid=0, out_ctrl=0, occupancy=0, and 0xC never appears.
- SKID_EN=0, toggle out_ready every cycle: in_ready equals !out_valid | out_ready in the same cycle; no data is lost or duplicated.
- STALL_CNT_W=2, stall for 6 cycles: stall_cnt reads 1,2,3,3,3,3.
- Assert reset asynchronously mid-stream between edges: all outputs go to 0 before the next edge; traffic resumes cleanly after release.
